// File: rtl/dnoc_itf_dma_wr_nbuf.sv
// DNoC DMA write channel: fills local dmem from NoC write data, either through an NBUF-deep
// buffer ring (core config) or as a single remote fill answered by a write response.
module dnoc_itf_dma_wr_nbuf #(
    parameter int unsigned DW   = 256,
    parameter int unsigned AW   = 13,
    parameter int unsigned NAW  = 25,
    parameter int unsigned NBUF = 2,
    parameter int unsigned LOOP = 4,
    parameter int unsigned FW   = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 c_req_i,
    output logic                 c_gnt_o,
    input  logic [NBUF*AW-1:0]   c_buf_base_i,
    input  logic [NBUF*AW-1:0]   c_buf_len_i,
    input  logic                 c_buf_en_i,
    input  logic [FW-1:0]        c_fill_num_i,
    input  logic [NAW-1:0]       c_noc_base_i,
    input  logic [LOOP*AW-1:0]   c_loop_len_i,
    input  logic [LOOP*AW-1:0]   c_loop_gap_i,
    input  logic                 n_req_i,
    output logic                 n_gnt_o,
    input  logic [AW-1:0]        n_base_i,
    input  logic [AW-1:0]        n_len_i,
    input  logic [3:0]           n_src_id_i,
    input  logic                 n_resp_sel_i,
    input  logic [LOOP*AW-1:0]   n_loop_len_i,
    input  logic [LOOP*AW-1:0]   n_loop_gap_i,
    input  logic [NBUF-1:0]      buf_busy_i,
    output logic [NBUF-1:0]      buf_wr_done_o,
    input  logic                 abort_i,
    input  logic [DW-1:0]        in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic                 out_req_o,
    input  logic                 out_gnt_i,
    output logic [NAW-1:0]       out_base_addr_o,
    output logic [AW-1:0]        out_len_o,
    output logic                 out_mode_o,
    output logic                 out_resp_sel_o,
    output logic                 done_o,
    output logic                 aborted_o,
    output logic                 mem_wr_en_o,
    output logic [AW-1:0]        mem_wr_addr_o,
    output logic [DW-1:0]        mem_wr_data_o
);
    localparam int unsigned BIW = (NBUF > 1) ? $clog2(NBUF) : 1;
    localparam int unsigned CW  = FW + 1;

    typedef enum logic [2:0] {StIdle, StBufCheck, StRdReq, StWr, StResp} state_e;

    state_e                  state_q, state_d;
    logic [NBUF-1:0][AW-1:0] buf_base_q, buf_base_d, buf_len_q, buf_len_d;
    logic [LOOP-1:0][AW-1:0] loop_len_q, loop_len_d, loop_gap_q, loop_gap_d;
    logic [LOOP-1:0][AW-1:0] idx_q, idx_d, row_q, row_d;
    logic                    buf_en_q, buf_en_d;
    logic [FW-1:0]           fill_num_q, fill_num_d;
    logic [CW-1:0]           fill_cnt_q, fill_cnt_d;
    logic [AW-1:0]           beat_cnt_q, beat_cnt_d;
    logic [BIW-1:0]          buf_idx_q, buf_idx_d;
    logic [NAW-1:0]          out_base_q, out_base_d;
    logic                    out_mode_q, out_mode_d, resp_sel_q, resp_sel_d;
    logic                    aborted_q, aborted_d;
    logic                    accept, gen_load, wrapped;
    logic [AW-1:0]           gen_base, cur_base, cur_len, step;
    logic                    unused_gap0;

    assign cur_base        = buf_base_q[buf_idx_q];
    assign cur_len         = buf_len_q[buf_idx_q];
    assign out_len_o       = cur_len;
    assign out_base_addr_o = out_base_q;
    assign out_mode_o      = out_mode_q;
    assign out_resp_sel_o  = resp_sel_q;
    assign aborted_o       = aborted_q;
    assign mem_wr_data_o   = in_data_i;
    assign mem_wr_addr_o   = row_q[0] + idx_q[0];
    assign unused_gap0     = ^loop_gap_q[0];

    always_comb begin
        state_d       = state_q;
        buf_base_d    = buf_base_q;
        buf_len_d     = buf_len_q;
        loop_len_d    = loop_len_q;
        loop_gap_d    = loop_gap_q;
        buf_en_d      = buf_en_q;
        fill_num_d    = fill_num_q;
        fill_cnt_d    = fill_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        buf_idx_d     = buf_idx_q;
        out_base_d    = out_base_q;
        out_mode_d    = out_mode_q;
        resp_sel_d    = resp_sel_q;
        aborted_d     = 1'b0;
        c_gnt_o       = 1'b0;
        n_gnt_o       = 1'b0;
        in_ready_o    = 1'b0;
        mem_wr_en_o   = 1'b0;
        out_req_o     = 1'b0;
        done_o        = 1'b0;
        buf_wr_done_o = '0;
        accept        = 1'b0;
        gen_load      = 1'b0;
        gen_base      = cur_base;
        // Outputs stay quiet while reset is held so a mid-transaction reset emits no pulses.
        if (!rst_i) begin
            if (abort_i && state_q != StIdle) begin
                state_d    = StIdle;
                beat_cnt_d = '0;
                fill_cnt_d = '0;
                buf_idx_d  = '0;
                aborted_d  = 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (c_req_i) begin
                            c_gnt_o    = 1'b1;
                            buf_base_d = c_buf_base_i;
                            buf_len_d  = c_buf_len_i;
                            buf_en_d   = c_buf_en_i;
                            fill_num_d = c_fill_num_i;
                            loop_len_d = c_loop_len_i;
                            loop_gap_d = c_loop_gap_i;
                            out_base_d = c_noc_base_i;
                            out_mode_d = 1'b0;
                            buf_idx_d  = '0;
                            fill_cnt_d = '0;
                            beat_cnt_d = '0;
                            state_d    = StRdReq;
                        end else if (n_req_i) begin
                            n_gnt_o       = 1'b1;
                            buf_base_d[0] = n_base_i;
                            buf_len_d[0]  = n_len_i;
                            buf_en_d      = 1'b0;
                            fill_num_d    = '0;
                            loop_len_d    = n_loop_len_i;
                            loop_gap_d    = n_loop_gap_i;
                            out_base_d    = NAW'({n_src_id_i, {AW{1'b0}}});
                            out_mode_d    = 1'b1;
                            resp_sel_d    = n_resp_sel_i;
                            buf_idx_d     = '0;
                            fill_cnt_d    = '0;
                            beat_cnt_d    = '0;
                            gen_load      = 1'b1;
                            gen_base      = n_base_i;
                            state_d       = StWr;
                        end
                    end
                    StRdReq: begin
                        out_req_o = 1'b1;
                        gen_load  = 1'b1;
                        if (out_gnt_i) state_d = StWr;
                    end
                    StWr: begin
                        in_ready_o  = in_valid_i;
                        mem_wr_en_o = in_valid_i;
                        accept      = in_valid_i;
                        if (in_valid_i) begin
                            if (beat_cnt_q == cur_len) begin
                                beat_cnt_d = '0;
                                if (out_mode_q) begin
                                    state_d = StResp;
                                end else begin
                                    buf_wr_done_o[buf_idx_q] = buf_en_q;
                                    out_base_d = out_base_q + NAW'(cur_len) + NAW'(1);
                                    fill_cnt_d = fill_cnt_q + CW'(1);
                                    buf_idx_d  = (buf_idx_q == BIW'(NBUF - 1)) ? '0
                                                                               : buf_idx_q + BIW'(1);
                                    state_d    = StBufCheck;
                                end
                            end else begin
                                beat_cnt_d = beat_cnt_q + AW'(1);
                            end
                        end
                    end
                    StBufCheck: begin
                        if (!buf_en_q || fill_cnt_q == ({1'b0, fill_num_q} + CW'(1))) begin
                            done_o     = 1'b1;
                            fill_cnt_d = '0;
                            state_d    = StIdle;
                        end else if (!buf_busy_i[buf_idx_q]) begin
                            state_d = StRdReq;
                        end
                    end
                    StResp: begin
                        out_req_o = 1'b1;
                        if (out_gnt_i) begin
                            done_o  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // Row-start registers: row_q[k] is the address where level k's current iteration began.
    always_comb begin
        idx_d   = idx_q;
        row_d   = row_q;
        wrapped = 1'b1;
        step    = '0;
        if (gen_load) begin
            idx_d = '0;
            row_d = {LOOP{gen_base}};
        end else if (accept) begin
            for (int k = 0; k < LOOP; k++) begin
                if (wrapped) begin
                    if (idx_q[k] != loop_len_q[k]) begin
                        wrapped  = 1'b0;
                        idx_d[k] = idx_q[k] + AW'(1);
                        if (k != 0) begin
                            step = row_q[k] + loop_gap_q[k];
                            for (int j = 0; j <= k; j++) row_d[j] = step;
                        end
                    end else begin
                        idx_d[k] = '0;
                    end
                end
            end
            if (wrapped) row_d = {LOOP{cur_base}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            buf_base_q <= '0;
            buf_len_q  <= '0;
            loop_len_q <= '0;
            loop_gap_q <= '0;
            idx_q      <= '0;
            row_q      <= '0;
            buf_en_q   <= 1'b0;
            fill_num_q <= '0;
            fill_cnt_q <= '0;
            beat_cnt_q <= '0;
            buf_idx_q  <= '0;
            out_base_q <= '0;
            out_mode_q <= 1'b0;
            resp_sel_q <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_base_q <= buf_base_d;
            buf_len_q  <= buf_len_d;
            loop_len_q <= loop_len_d;
            loop_gap_q <= loop_gap_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            buf_en_q   <= buf_en_d;
            fill_num_q <= fill_num_d;
            fill_cnt_q <= fill_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            buf_idx_q  <= buf_idx_d;
            out_base_q <= out_base_d;
            out_mode_q <= out_mode_d;
            resp_sel_q <= resp_sel_d;
            aborted_q  <= aborted_d;
        end
    end

endmodule

// File: tb/tb_dnoc_itf_dma_wr_nbuf.sv
// Bench for dnoc_itf_dma_wr_nbuf: directed scenarios plus randomized configs, checked against
// an arithmetic model of the ring/loop address sequence and NoC request stream.
`timescale 1ns/100ps
module tb_dnoc_itf_dma_wr_nbuf;
    localparam int AW = 13, NAW = 25, NBUF = 2, LOOP = 4, FW = 11, DW = 256;

    logic clk = 1'b0, rst = 1'b1;
    logic c_req = 0, c_gnt, c_buf_en = 0, n_req = 0, n_gnt, n_resp_sel = 0, abort = 0;
    logic [NBUF*AW-1:0] c_buf_base = '0, c_buf_len = '0;
    logic [FW-1:0] c_fill_num = '0;
    logic [NAW-1:0] c_noc_base = '0, out_base_addr;
    logic [LOOP*AW-1:0] c_loop_len = '0, c_loop_gap = '0, n_loop_len = '0, n_loop_gap = '0;
    logic [AW-1:0] n_base = '0, n_len = '0, out_len, mem_wr_addr;
    logic [3:0] n_src_id = '0;
    logic [NBUF-1:0] buf_busy = '0, buf_wr_done;
    logic [DW-1:0] in_data = '0, mem_wr_data;
    logic in_valid = 0, in_ready, out_req, out_gnt = 0, out_mode, out_resp_sel;
    logic done, aborted, mem_wr_en;

    always #5 clk = ~clk;

    dnoc_itf_dma_wr_nbuf dut (
        .clk_i(clk), .rst_i(rst), .c_req_i(c_req), .c_gnt_o(c_gnt),
        .c_buf_base_i(c_buf_base), .c_buf_len_i(c_buf_len), .c_buf_en_i(c_buf_en),
        .c_fill_num_i(c_fill_num), .c_noc_base_i(c_noc_base), .c_loop_len_i(c_loop_len),
        .c_loop_gap_i(c_loop_gap), .n_req_i(n_req), .n_gnt_o(n_gnt), .n_base_i(n_base),
        .n_len_i(n_len), .n_src_id_i(n_src_id), .n_resp_sel_i(n_resp_sel),
        .n_loop_len_i(n_loop_len), .n_loop_gap_i(n_loop_gap), .buf_busy_i(buf_busy),
        .buf_wr_done_o(buf_wr_done), .abort_i(abort), .in_data_i(in_data),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .out_req_o(out_req),
        .out_gnt_i(out_gnt), .out_base_addr_o(out_base_addr), .out_len_o(out_len),
        .out_mode_o(out_mode), .out_resp_sel_o(out_resp_sel), .done_o(done),
        .aborted_o(aborted), .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr),
        .mem_wr_data_o(mem_wr_data)
    );

    int checks = 0, errors = 0;
    logic src_en = 0, force_valid = 0;

    // Source and NoC grant: random bubbles, fresh data each cycle.
    always @(posedge clk) begin
        #2;
        in_valid = src_en && (force_valid || ($urandom_range(0, 3) != 0));
        in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        out_gnt  = ($urandom_range(0, 1) == 1);
    end

    logic [AW-1:0]    obs_addr[$];
    logic [NAW+AW:0]  obs_req[$];
    logic [NBUF-1:0]  obs_wd[$];
    int done_cnt = 0, ab_cnt = 0, data_bad = 0, hs_bad = 0;

    always @(negedge clk) begin
        if (mem_wr_en) begin
            obs_addr.push_back(mem_wr_addr);
            if (mem_wr_data !== in_data) data_bad++;
        end
        if (mem_wr_en !== (in_valid && in_ready)) hs_bad++;
        if (out_req && out_gnt) obs_req.push_back({out_mode, out_len, out_base_addr});
        if (buf_wr_done != '0) obs_wd.push_back(buf_wr_done);
        if (done) done_cnt++;
        if (aborted) ab_cnt++;
    end

    // Configuration shared by stimulus and model
    logic [AW-1:0]  cb_base[NBUF], cb_len[NBUF], ll[LOOP], lg[LOOP];
    logic           c_en;
    logic [FW-1:0]  c_fnum;
    logic [NAW-1:0] c_noc;
    logic [AW-1:0]  exp_addr[$];
    logic [NAW+AW:0] exp_req[$];
    logic [NBUF-1:0] exp_wd[$];
    int s_addr, s_req, s_wd, s_done, s_ab, s_bad, s_hs;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat number -> address by mixed-radix decomposition over loop counts.
    function automatic logic [AW-1:0] gen_addr(input logic [AW-1:0] base, input int beat);
        longint total = 1, r;
        longint d;
        logic [AW-1:0] a = base;
        for (int k = 0; k < LOOP; k++) total = total * (longint'(ll[k]) + 1);
        r = longint'(beat) % total;
        for (int k = 0; k < LOOP; k++) begin
            d = r % (longint'(ll[k]) + 1);
            r = r / (longint'(ll[k]) + 1);
            a = a + ((k == 0) ? AW'(d) : AW'(d * longint'(lg[k])));
        end
        return a;
    endfunction

    task automatic snap();
        s_addr = obs_addr.size(); s_req = obs_req.size(); s_wd = obs_wd.size();
        s_done = done_cnt; s_ab = ab_cnt; s_bad = data_bad; s_hs = hs_bad;
        exp_addr.delete(); exp_req.delete(); exp_wd.delete();
    endtask

    task automatic model_core();
        logic [NAW-1:0] nb = c_noc;
        int fills = c_en ? int'(c_fnum) + 1 : 1;
        for (int f = 0; f < fills; f++) begin
            int b = f % NBUF;
            exp_req.push_back({1'b0, cb_len[b], nb});
            for (int i = 0; i <= int'(cb_len[b]); i++) exp_addr.push_back(gen_addr(cb_base[b], i));
            if (c_en) exp_wd.push_back(NBUF'(1) << b);
            nb = nb + NAW'(cb_len[b]) + NAW'(1);
        end
    endtask

    task automatic model_remote();
        for (int i = 0; i <= int'(n_len); i++) exp_addr.push_back(gen_addr(n_base, i));
        exp_req.push_back({1'b1, n_len, NAW'({n_src_id, {AW{1'b0}}})});
    endtask

    task automatic drive_core();
        for (int b = 0; b < NBUF; b++) begin
            c_buf_base[b*AW +: AW] = cb_base[b];
            c_buf_len[b*AW +: AW]  = cb_len[b];
        end
        for (int k = 0; k < LOOP; k++) begin
            c_loop_len[k*AW +: AW] = ll[k];
            c_loop_gap[k*AW +: AW] = lg[k];
        end
        c_buf_en = c_en; c_fill_num = c_fnum; c_noc_base = c_noc;
    endtask

    task automatic drive_remote();
        for (int k = 0; k < LOOP; k++) begin
            n_loop_len[k*AW +: AW] = ll[k];
            n_loop_gap[k*AW +: AW] = lg[k];
        end
    endtask

    task automatic rand_core();
        for (int b = 0; b < NBUF; b++) begin
            cb_base[b] = AW'($urandom);
            cb_len[b]  = AW'($urandom_range(0, 7));
        end
        for (int k = 0; k < LOOP; k++) begin
            ll[k] = AW'($urandom_range(0, 3));
            lg[k] = AW'($urandom);
        end
        c_en = 1'($urandom_range(0, 1)); c_fnum = FW'($urandom_range(0, 4));
        c_noc = NAW'($urandom);
    endtask

    task automatic rand_remote();
        for (int k = 0; k < LOOP; k++) begin
            ll[k] = AW'($urandom_range(0, 3));
            lg[k] = AW'($urandom);
        end
        n_base = AW'($urandom); n_len = AW'($urandom_range(0, 9));
        n_src_id = 4'($urandom); n_resp_sel = 1'($urandom_range(0, 1));
    endtask

    task automatic start_core();
        drive_core();
        c_req = 1'b1;
        #1;
        check("c_gnt", 64'(c_gnt), 64'd1);
        @(posedge clk); #1;
        c_req = 1'b0;
        model_core();
    endtask

    task automatic start_remote();
        int n = 0;
        drive_remote();
        n_req = 1'b1;
        #1;
        while (!n_gnt && n < 2000) begin @(posedge clk); #1; n++; end
        check("n_gnt_seen", 64'(n_gnt), 64'd1);
        @(posedge clk); #1;
        n_req = 1'b0;
        model_remote();
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin @(posedge clk); #1; n++; end
        check("done_in_time", 64'(done_cnt >= target), 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag, input int ndone);
        check({tag, "_nwr"}, 64'(obs_addr.size() - s_addr), 64'(exp_addr.size()));
        foreach (exp_addr[i])
            if (s_addr + i < obs_addr.size())
                check($sformatf("%s_addr%0d", tag, i), 64'(obs_addr[s_addr + i]), 64'(exp_addr[i]));
        check({tag, "_nreq"}, 64'(obs_req.size() - s_req), 64'(exp_req.size()));
        foreach (exp_req[i])
            if (s_req + i < obs_req.size())
                check($sformatf("%s_req%0d", tag, i), 64'(obs_req[s_req + i]), 64'(exp_req[i]));
        check({tag, "_nwd"}, 64'(obs_wd.size() - s_wd), 64'(exp_wd.size()));
        foreach (exp_wd[i])
            if (s_wd + i < obs_wd.size())
                check($sformatf("%s_wd%0d", tag, i), 64'(obs_wd[s_wd + i]), 64'(exp_wd[i]));
        check({tag, "_done"}, 64'(done_cnt - s_done), 64'(ndone));
        check({tag, "_aborted"}, 64'(ab_cnt - s_ab), 64'd0);
        check({tag, "_data"}, 64'(data_bad - s_bad), 64'd0);
        check({tag, "_handshake"}, 64'(hs_bad - s_hs), 64'd0);
    endtask

    initial begin
        int n, cnt;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; src_en = 1'b1; force_valid = 1'b1;
        @(posedge clk); #1;
        check("rst_out_base", 64'(out_base_addr), 64'd0);
        check("rst_out_mode", 64'(out_mode), 64'd0);
        check("rst_resp_sel", 64'(out_resp_sel), 64'd0);
        check("rst_out_req", 64'(out_req), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_wr_en", 64'(mem_wr_en), 64'd0);
        check("rst_pulses", 64'({done, aborted, buf_wr_done}), 64'd0);
        force_valid = 1'b0;

        // Ring: 4 fills of 4 beats, linear addressing
        snap();
        cb_base[0] = 13'h100; cb_base[1] = 13'h200; cb_len[0] = 13'd3; cb_len[1] = 13'd3;
        c_en = 1'b1; c_fnum = 11'd3; c_noc = '0;
        ll[0] = 13'h1fff; lg[0] = '0;
        for (int k = 1; k < LOOP; k++) begin ll[k] = '0; lg[k] = '0; end
        start_core(); wait_done(s_done + 1); compare("ring", 1);

        // Two-level loop addressing
        snap();
        cb_base[0] = 13'h40; cb_len[0] = 13'd5; c_en = 1'b0; c_fnum = '0;
        ll[0] = 13'd1; ll[1] = 13'd2; lg[1] = 13'h10;
        start_core(); wait_done(s_done + 1); compare("loop", 1);
        if (obs_addr.size() >= s_addr + 6) begin
            check("loop_addr2_const", 64'(obs_addr[s_addr + 2]), 64'h50);
            check("loop_addr5_const", 64'(obs_addr[s_addr + 5]), 64'h61);
        end

        // Consumer holds buffer 1 busy after the first fill
        snap(); rand_core(); c_en = 1'b1; c_fnum = 11'd1;
        buf_busy = 2'b10;
        start_core();
        n = 0;
        while (obs_wd.size() == s_wd && n < 1000) begin @(posedge clk); #1; n++; end
        check("busy_first_fill", 64'(obs_wd.size() - s_wd), 64'd1);
        cnt = 0;
        repeat (20) begin @(posedge clk); #1; if (out_req) cnt++; end
        check("busy_no_out_req", 64'(cnt), 64'd0);
        check("busy_req_count", 64'(obs_req.size() - s_req), 64'd1);
        buf_busy = '0;
        wait_done(s_done + 1); compare("busy", 1);

        // Remote fill with write response
        snap();
        for (int k = 0; k < LOOP; k++) begin ll[k] = AW'($urandom_range(0, 2)); lg[k] = AW'($urandom); end
        n_base = 13'h0123; n_len = 13'd2; n_src_id = 4'd5; n_resp_sel = 1'b1;
        start_remote(); wait_done(s_done + 1); compare("remote", 1);
        check("remote_resp_sel", 64'(out_resp_sel), 64'd1);
        check("remote_out_mode", 64'(out_mode), 64'd1);

        // Simultaneous core and remote requests: core wins, remote follows
        snap(); rand_core(); drive_core();
        c_req = 1'b1; n_req = 1'b1;
        #1;
        check("both_c_gnt", 64'(c_gnt), 64'd1);
        check("both_n_gnt", 64'(n_gnt), 64'd0);
        @(posedge clk); #1;
        c_req = 1'b0;
        model_core();
        n_base = AW'($urandom); n_len = AW'($urandom_range(0, 5)); n_src_id = 4'($urandom);
        for (int k = 0; k < LOOP; k++) begin ll[k] = AW'($urandom_range(0, 3)); lg[k] = AW'($urandom); end
        start_remote();
        check("both_core_done_first", 64'(done_cnt - s_done), 64'd1);
        wait_done(s_done + 2); compare("both", 2);

        // Abort on the third beat of four
        snap(); rand_core(); c_en = 1'b0; cb_len[0] = 13'd3; ll[0] = 13'h1fff;
        for (int k = 1; k < LOOP; k++) ll[k] = '0;
        force_valid = 1'b1;
        start_core();
        n = 0;
        while (obs_addr.size() < s_addr + 2 && n < 1000) begin @(posedge clk); #1; n++; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; force_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_nwr", 64'(obs_addr.size() - s_addr), 64'd2);
        check("abort_pulse", 64'(ab_cnt - s_ab), 64'd1);
        check("abort_no_done", 64'(done_cnt - s_done), 64'd0);
        check("abort_no_wd", 64'(obs_wd.size() - s_wd), 64'd0);
        check("abort_idle", 64'(out_req), 64'd0);
        if (obs_addr.size() >= s_addr + 2)
            check("abort_addr1", 64'(obs_addr[s_addr + 1]), 64'(exp_addr[1]));
        snap(); rand_core(); start_core(); wait_done(s_done + 1); compare("post_abort", 1);

        // Reset in the middle of a write burst
        snap(); rand_core(); c_en = 1'b1; c_fnum = 11'd2; cb_len[0] = 13'd5;
        start_core();
        n = 0;
        while (obs_addr.size() < s_addr + 1 && n < 1000) begin @(posedge clk); #1; n++; end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_no_pulse", 64'((done_cnt - s_done) + (ab_cnt - s_ab)), 64'd0);
        check("rst_mid_no_wd", 64'(obs_wd.size() - s_wd), 64'd0);
        check("rst_mid_base", 64'(out_base_addr), 64'd0);
        check("rst_mid_req", 64'(out_req), 64'd0);
        snap(); rand_core(); start_core(); wait_done(s_done + 1); compare("post_rst", 1);

        // Randomized mix
        for (int it = 0; it < 8; it++) begin
            snap();
            if ($urandom_range(0, 2) == 0) begin
                rand_remote(); start_remote();
            end else begin
                rand_core(); start_core();
            end
            wait_done(s_done + 1);
            compare($sformatf("rand%0d", it), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
